// File: rtl/ahb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// ahb_rr_arbiter
//   Round-robin AHB bus arbiter for 2..4 masters. Grants are re-evaluated
//   only at arbitration points: the bus is ready, not locked, no fixed-length
//   burst is running, and the owner has released (request low or IDLE).
//   With no requester the grant parks on the last owner.
//
// Optional feature (macro ARB_TIMEOUT_EN):
//   Adds a tenure counter. After TIMEOUT_CYCLES owner cycles with another
//   master waiting, the owner is forced out at the next ready arbitration
//   opportunity and excluded from that round.
//
// Ports:
//   HCLK          bus clock, rising edge
//   HRESET        synchronous reset, active high
//   hbusreq       per-master request level
//   HTRANS        shared-bus transfer type
//   HBURST        shared-bus burst type
//   HMASTLOCK     shared-bus lock
//   HREADY        shared-bus ready
//   hgrant        one-hot address-phase grant
//   hmaster       binary index of the granted master
//   hmaster_data  index of the master owning the current data phase
// ---------------------------------------------------------------------------
module ahb_rr_arbiter #(
    parameter int NUM_MASTERS    = 2,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                   HCLK,
    input  logic                   HRESET,
    input  logic [NUM_MASTERS-1:0] hbusreq,
    input  logic [1:0]             HTRANS,
    input  logic [2:0]             HBURST,
    input  logic                   HMASTLOCK,
    input  logic                   HREADY,
    output logic [NUM_MASTERS-1:0] hgrant,
    output logic [1:0]             hmaster,
    output logic [1:0]             hmaster_data
);

    if (NUM_MASTERS < 2 || NUM_MASTERS > 4 || TIMEOUT_CYCLES < 2) begin : g_param_check
        $error("ahb_rr_arbiter: illegal parameter value");
    end

    localparam logic [1:0] TRANS_IDLE   = 2'b00;
    localparam logic [1:0] TRANS_NONSEQ = 2'b10;
    localparam logic [1:0] TRANS_SEQ    = 2'b11;

    typedef enum logic {PARK, OWNED} state_t;
    state_t state;

    logic [4:0] beat_cnt;
    logic [4:0] burst_len;
    logic [3:0] req_pad;
    logic [3:0] owner_mask;
    logic [3:0] grant_pad;
    logic [1:0] winner;
    logic [1:0] cand;
    logic       owner_req;
    logic       other_req;
    logic       burst_active;
    logic       burst_start;
    logic       timeout_hit;
    logic       arb_en;
    logic       found;

    // Requests widened to four lanes so the 2-bit hmaster can index them
    // for any legal NUM_MASTERS; unused lanes stay zero.
    always_comb begin
        req_pad                  = 4'b0000;
        req_pad[NUM_MASTERS-1:0] = hbusreq;
    end

    assign owner_mask   = 4'b0001 << hmaster;
    assign owner_req    = |(req_pad & owner_mask);
    assign other_req    = |(req_pad & ~owner_mask);
    assign burst_active = (beat_cnt != 5'd0);
    assign burst_start  = HREADY && (HTRANS == TRANS_NONSEQ) && (HBURST >= 3'd2);

    // Remaining SEQ beats after the NONSEQ of a fixed-length burst.
    always_comb begin
        case (HBURST[2:1])
            2'b01:   burst_len = 5'd3;
            2'b10:   burst_len = 5'd7;
            2'b11:   burst_len = 5'd15;
            default: burst_len = 5'd0;
        endcase
    end

    // Round-robin search starting one past the current owner; the owner is
    // considered last, and skipped entirely when forced out by timeout.
    always_comb begin
        found  = 1'b0;
        winner = hmaster;
        cand   = hmaster;
        for (int k = 1; k <= NUM_MASTERS; k++) begin
            cand = 2'((int'(hmaster) + k) % NUM_MASTERS);
            if (!found && req_pad[cand] && !(timeout_hit && cand == hmaster)) begin
                found  = 1'b1;
                winner = cand;
            end
        end
    end

    assign grant_pad = 4'b0001 << winner;

`ifdef ARB_TIMEOUT_EN
    localparam int            TW         = $clog2(TIMEOUT_CYCLES);
    localparam logic [TW-1:0] TENURE_MAX = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tenure_cnt;

    assign timeout_hit = (state == OWNED) && (tenure_cnt == TENURE_MAX) && other_req;

    // Saturates so a pending expiry survives wait states, locks and bursts.
    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            tenure_cnt <= '0;
        end else if (state == PARK || (arb_en && found && winner != hmaster)) begin
            tenure_cnt <= '0;
        end else if (tenure_cnt != TENURE_MAX) begin
            tenure_cnt <= tenure_cnt + 1'b1;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    // A burst start on this edge wins over any competing request.
    always_comb begin
        arb_en = HREADY && !HMASTLOCK && !burst_active && !burst_start;
        if (state == OWNED) begin
            arb_en = arb_en && (!owner_req || HTRANS == TRANS_IDLE || timeout_hit);
        end
    end

    always_ff @(posedge HCLK) begin
        if (HRESET) begin
            state        <= PARK;
            hgrant       <= NUM_MASTERS'(1);
            hmaster      <= 2'd0;
            hmaster_data <= 2'd0;
            beat_cnt     <= 5'd0;
        end else begin
            if (HREADY) begin
                hmaster_data <= hmaster;
            end

            if (burst_start) begin
                beat_cnt <= burst_len;
            end else if (HREADY && burst_active) begin
                if (HTRANS == TRANS_SEQ) begin
                    beat_cnt <= beat_cnt - 5'd1;
                end else if (HTRANS == TRANS_IDLE) begin
                    beat_cnt <= 5'd0;
                end
            end

            if (arb_en) begin
                if (found) begin
                    state   <= OWNED;
                    hmaster <= winner;
                    hgrant  <= grant_pad[NUM_MASTERS-1:0];
                end else begin
                    state <= PARK;
                end
            end
        end
    end

endmodule

// File: tb/tb_ahb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_ahb_rr_arbiter
//   Directed scenarios with hand-derived expectations, followed by a
//   randomized run compared every cycle against a rule-level model of the
//   arbiter. Three masters are instantiated so the round-robin wrap and the
//   skip over a silent master are exercised.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_ahb_rr_arbiter;

    localparam int N = 3;
    localparam int T = 16;

    localparam logic [1:0] IDLE   = 2'b00;
    localparam logic [1:0] BUSY   = 2'b01;
    localparam logic [1:0] NONSEQ = 2'b10;
    localparam logic [1:0] SEQ    = 2'b11;

`ifdef ARB_TIMEOUT_EN
    localparam bit TO_EN  = 1'b1;
    localparam int TO_LEN = 24;
`else
    localparam bit TO_EN  = 1'b0;
    localparam int TO_LEN = 40;
`endif

    logic         HCLK = 1'b0;
    logic         HRESET;
    logic [N-1:0] hbusreq;
    logic [1:0]   HTRANS;
    logic [2:0]   HBURST;
    logic         HMASTLOCK;
    logic         HREADY;
    logic [N-1:0] hgrant;
    logic [1:0]   hmaster;
    logic [1:0]   hmaster_data;

    always #5 HCLK = ~HCLK;

    ahb_rr_arbiter #(
        .NUM_MASTERS   (N),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .HCLK        (HCLK),
        .HRESET      (HRESET),
        .hbusreq     (hbusreq),
        .HTRANS      (HTRANS),
        .HBURST      (HBURST),
        .HMASTLOCK   (HMASTLOCK),
        .HREADY      (HREADY),
        .hgrant      (hgrant),
        .hmaster     (hmaster),
        .hmaster_data(hmaster_data)
    );

    int checks = 0;
    int errors = 0;

    // Reference model: owner index, parked flag, beats left in a fixed
    // burst, owner tenure in cycles, data-phase owner.
    int m_owner  = 0;
    bit m_parked = 1'b1;
    int m_beats  = 0;
    int m_tenure = 0;
    int m_data   = 0;

    task automatic model_edge();
        int prev_owner;
        bit prev_parked;
        bit timeout;
        bit fixed_start;
        bit handover;
        int pick;
        int c;
        if (HRESET) begin
            m_owner = 0; m_parked = 1'b1; m_beats = 0; m_tenure = 0; m_data = 0;
            return;
        end
        prev_owner  = m_owner;
        prev_parked = m_parked;
        timeout     = 1'b0;
`ifdef ARB_TIMEOUT_EN
        if (!m_parked && m_tenure >= T - 1) begin
            for (int k = 0; k < N; k++) begin
                if (k != m_owner && hbusreq[k]) timeout = 1'b1;
            end
        end
`endif
        fixed_start = HREADY && HTRANS == NONSEQ && HBURST >= 3'd2;
        handover    = HREADY && !HMASTLOCK && m_beats == 0 && !fixed_start &&
                      (m_parked || !hbusreq[m_owner] || HTRANS == IDLE || timeout);
        if (HREADY) m_data = m_owner;
        if (fixed_start) m_beats = (2 << (HBURST / 2)) - 1;
        else if (HREADY && m_beats > 0 && HTRANS == SEQ) m_beats--;
        else if (HREADY && m_beats > 0 && HTRANS == IDLE) m_beats = 0;
        if (handover) begin
            pick = -1;
            for (int k = 1; k <= N; k++) begin
                c = (prev_owner + k) % N;
                if (pick < 0 && hbusreq[c] && !(timeout && c == prev_owner)) pick = c;
            end
            if (pick < 0) begin
                m_parked = 1'b1;
            end else begin
                m_parked = 1'b0;
                m_owner  = pick;
            end
        end
        if (prev_parked || m_owner != prev_owner) m_tenure = 0;
        else if (m_tenure < T - 1) m_tenure++;
    endtask

    task automatic step();
        @(posedge HCLK);
        model_edge();
        #1;
    endtask

    task automatic test_reset();
        HRESET = 1'b1; hbusreq = '0; HTRANS = IDLE; HBURST = 3'b000;
        HMASTLOCK = 1'b0; HREADY = 1'b1;
        step(); step();
        checks++; if (hgrant !== 3'b001) begin errors++; $display("FAIL reset_hgrant: got %b want 001", hgrant); end
        checks++; if (hmaster !== 2'd0) begin errors++; $display("FAIL reset_hmaster: got %0d want 0", hmaster); end
        checks++; if (hmaster_data !== 2'd0) begin errors++; $display("FAIL reset_hmaster_data: got %0d want 0", hmaster_data); end
        HRESET = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step();
            checks++; if (hgrant !== 3'b001 || hmaster !== 2'd0 || hmaster_data !== 2'd0) begin
                errors++;
                $display("FAIL idle_park cycle %0d: got grant=%b master=%0d data=%0d want 001/0/0", i, hgrant, hmaster, hmaster_data);
            end
        end
    endtask

    task automatic test_round_robin();
        int exp_owner;
        int exp_data;
        logic [N-1:0] eg;
        hbusreq = 3'b001; HTRANS = IDLE; HBURST = 3'b000;
        step();
        checks++; if (hgrant !== 3'b001) begin errors++; $display("FAIL rr_claim: got %b want 001", hgrant); end
        exp_owner = 0;
        hbusreq   = 3'b011;
        for (int i = 0; i < 4; i++) begin
            HTRANS = NONSEQ; step();
            exp_data = exp_owner;
            eg = '0; eg[exp_owner] = 1'b1;
            checks++; if (hgrant !== eg || hmaster_data !== 2'(exp_data)) begin
                errors++;
                $display("FAIL rr_hold %0d: got grant=%b data=%0d want %b/%0d", i, hgrant, hmaster_data, eg, exp_data);
            end
            HTRANS = IDLE; step();
            exp_data  = exp_owner;
            exp_owner = 1 - exp_owner;
            eg = '0; eg[exp_owner] = 1'b1;
            checks++; if (hgrant !== eg || hmaster !== 2'(exp_owner) || hmaster_data !== 2'(exp_data)) begin
                errors++;
                $display("FAIL rr_switch %0d: got grant=%b master=%0d data=%0d want %b/%0d/%0d",
                         i, hgrant, hmaster, hmaster_data, eg, exp_owner, exp_data);
            end
        end
    endtask

    // M0 owns; M0 drops its request during the beats so only the beat
    // counter holds the grant. A BUSY sits between beats 3 and 4.
    task automatic test_burst();
        hbusreq = 3'b011; HTRANS = NONSEQ; HBURST = 3'b011; HREADY = 1'b1;
        step();
        checks++; if (hgrant !== 3'b001) begin errors++; $display("FAIL burst_nonseq: got %b want 001", hgrant); end
        hbusreq = 3'b010; HTRANS = SEQ; HREADY = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (hgrant !== 3'b001 || hmaster_data !== 2'd0) begin
                errors++; $display("FAIL burst_wait %0d: got grant=%b data=%0d want 001/0", i, hgrant, hmaster_data);
            end
        end
        HREADY = 1'b1;
        step();
        checks++; if (hgrant !== 3'b001) begin errors++; $display("FAIL burst_beat2: got %b want 001", hgrant); end
        step();
        checks++; if (hgrant !== 3'b001) begin errors++; $display("FAIL burst_beat3: got %b want 001", hgrant); end
        HTRANS = BUSY; step();
        checks++; if (hgrant !== 3'b001) begin errors++; $display("FAIL burst_busy: got %b want 001", hgrant); end
        HTRANS = SEQ; step();
        checks++; if (hgrant !== 3'b001) begin errors++; $display("FAIL burst_beat4: got %b want 001", hgrant); end
        HTRANS = IDLE; step();
        checks++; if (hgrant !== 3'b010 || hmaster !== 2'd1) begin
            errors++; $display("FAIL burst_handover: got grant=%b master=%0d want 010/1", hgrant, hmaster);
        end
    endtask

    // M1 owns and does not request; only the lock keeps the grant.
    task automatic test_lock();
        hbusreq = 3'b001; HMASTLOCK = 1'b1; HBURST = 3'b000; HREADY = 1'b1;
        for (int i = 0; i < 6; i++) begin
            HTRANS = (i % 2 == 0) ? NONSEQ : IDLE;
            step();
            checks++; if (hgrant !== 3'b010) begin errors++; $display("FAIL lock_hold %0d: got %b want 010", i, hgrant); end
        end
        HMASTLOCK = 1'b0; HTRANS = IDLE;
        step();
        checks++; if (hgrant !== 3'b001) begin errors++; $display("FAIL lock_release: got %b want 001", hgrant); end
    endtask

    task automatic test_data_hold();
        checks++; if (hmaster_data !== 2'd1) begin errors++; $display("FAIL data_pre: got %0d want 1", hmaster_data); end
        hbusreq = 3'b010; HTRANS = IDLE; HREADY = 1'b1;
        step();
        checks++; if (hgrant !== 3'b010 || hmaster_data !== 2'd0) begin
            errors++; $display("FAIL data_grant: got grant=%b data=%0d want 010/0", hgrant, hmaster_data);
        end
        HTRANS = NONSEQ; HREADY = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step();
            checks++; if (hmaster_data !== 2'd0 || hmaster !== 2'd1) begin
                errors++; $display("FAIL data_wait %0d: got data=%0d master=%0d want 0/1", i, hmaster_data, hmaster);
            end
        end
        HREADY = 1'b1;
        step();
        checks++; if (hmaster_data !== 2'd1) begin errors++; $display("FAIL data_load: got %0d want 1", hmaster_data); end
    endtask

    task automatic test_reset_mid_burst();
        hbusreq = 3'b010; HTRANS = NONSEQ; HBURST = 3'b101; HREADY = 1'b1;
        step();
        HTRANS = SEQ; step();
        checks++; if (hgrant !== 3'b010) begin errors++; $display("FAIL rmb_owner: got %b want 010", hgrant); end
        HRESET = 1'b1; step();
        checks++; if (hgrant !== 3'b001 || hmaster_data !== 2'd0) begin
            errors++; $display("FAIL rmb_reset: got grant=%b data=%0d want 001/0", hgrant, hmaster_data);
        end
        HRESET = 1'b0; hbusreq = 3'b001; HTRANS = IDLE; step();
        hbusreq = 3'b010; HTRANS = SEQ; step();
        checks++; if (hgrant !== 3'b010) begin errors++; $display("FAIL rmb_no_stale_burst: got %b want 010", hgrant); end
    endtask

    task automatic test_timeout();
        logic [N-1:0] eg;
        HRESET = 1'b1; hbusreq = '0; HTRANS = IDLE; HMASTLOCK = 1'b0; HREADY = 1'b1;
        step();
        HRESET = 1'b0; hbusreq = 3'b001; HTRANS = NONSEQ; HBURST = 3'b001;
        step();
        hbusreq = 3'b011;
        for (int i = 1; i <= TO_LEN; i++) begin
            HTRANS = (i % 4 == 1) ? NONSEQ : SEQ;
            step();
            eg = (TO_EN && i >= T) ? 3'b010 : 3'b001;
            checks++; if (hgrant !== eg) begin
                errors++; $display("FAIL tenure owner_cycle %0d: got %b want %b", i, hgrant, eg);
            end
        end
    endtask

    task automatic test_random();
        logic [N-1:0] eg;
        HRESET = 1'b1; step();
        for (int i = 0; i < 3000; i++) begin
            if (i < 1500) begin
                hbusreq   = N'($urandom_range(0, 7));
                HTRANS    = 2'($urandom_range(0, 3));
                HMASTLOCK = ($urandom_range(0, 7) == 0);
            end else begin
                hbusreq   = ($urandom_range(0, 3) == 0) ? N'($urandom_range(0, 7)) : 3'b111;
                HTRANS    = ($urandom_range(0, 15) == 0) ? IDLE : 2'($urandom_range(1, 3));
                HMASTLOCK = ($urandom_range(0, 31) == 0);
            end
            HBURST = 3'($urandom_range(0, 7));
            HREADY = ($urandom_range(0, 3) != 0);
            HRESET = ($urandom_range(0, 299) == 0);
            step();
            eg = '0; eg[m_owner] = 1'b1;
            checks++; if (hgrant !== eg) begin
                errors++; $display("FAIL rand_hgrant cycle %0d: got %b want %b", i, hgrant, eg);
            end
            checks++; if (hmaster !== 2'(m_owner)) begin
                errors++; $display("FAIL rand_hmaster cycle %0d: got %0d want %0d", i, hmaster, m_owner);
            end
            checks++; if (hmaster_data !== 2'(m_data)) begin
                errors++; $display("FAIL rand_hmaster_data cycle %0d: got %0d want %0d", i, hmaster_data, m_data);
            end
        end
        HRESET = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_round_robin();
        test_burst();
        test_lock();
        test_data_hold();
        test_reset_mid_burst();
        test_timeout();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
